// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Owns the single port of the data SRAM and shares it between the pipeline
// MEM stage and a loader requester (testbench preload / memory dump engine).
// The pipeline has priority by default. A starvation counter forces a bounded
// loader burst during which the pipeline is stalled. The SRAM has one cycle of
// read latency, so a per-requester valid flag records who issued the read and
// steers the returning data.
//
// Ports
//   CLK, RST                      clock (rising edge), synchronous active-high reset
//   P_REQ/P_WE/P_ADDR/P_WDATA     pipeline request (held while P_STALL=1)
//   P_STALL                       pipeline request denied this cycle
//   P_RVALID/P_RDATA              pipeline read return (one cycle after grant)
//   L_VALID/L_WE/L_LAST/L_ADDR/L_WDATA  loader beat
//   L_READY                       loader beat accepted this cycle
//   L_RVALID/L_RDATA              loader read return (one cycle after grant)
//   MEM_csb0/web0/addr0/din0      SRAM port drive (active-low selects)
//   MEM_dout0                     SRAM read data
//   LOAD_OWN                      1 while the loader owns the port
module dmem_port_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 16
) (
  input  logic              CLK,
  input  logic              RST,
  // Pipeline MEM stage
  input  logic              P_REQ,
  input  logic              P_WE,
  input  logic [ADDR_W-1:0] P_ADDR,
  input  logic [DATA_W-1:0] P_WDATA,
  output logic              P_STALL,
  output logic              P_RVALID,
  output logic [DATA_W-1:0] P_RDATA,
  // Loader
  input  logic              L_VALID,
  input  logic              L_WE,
  input  logic              L_LAST,
  input  logic [ADDR_W-1:0] L_ADDR,
  input  logic [DATA_W-1:0] L_WDATA,
  output logic              L_READY,
  output logic              L_RVALID,
  output logic [DATA_W-1:0] L_RDATA,
  // SRAM port
  output logic              MEM_csb0,
  output logic              MEM_web0,
  output logic [ADDR_W-1:0] MEM_addr0,
  output logic [DATA_W-1:0] MEM_din0,
  input  logic [DATA_W-1:0] MEM_dout0,
  // Status
  output logic              LOAD_OWN
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  // Terminal counts: reaching these on a qualifying cycle ends the phase.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

  typedef enum logic {
    ST_PIPE_OWN = 1'b0,
    ST_LOAD_OWN = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                p_rvalid_q, p_rvalid_d;
  logic                l_rvalid_q, l_rvalid_d;

  logic                p_gnt;
  logic                l_gnt;

  // ---------------------------------------------------------------------------
  // Grant selection. Reset suppresses every grant so the SRAM sees no access
  // while the arbiter is being initialised.
  // ---------------------------------------------------------------------------
  always_comb begin
    p_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!RST) begin
      unique case (state_q)
        ST_PIPE_OWN: begin
          p_gnt = P_REQ;
          l_gnt = !P_REQ && L_VALID;
        end
        ST_LOAD_OWN: begin
          // The pipeline may use an idle burst cycle; the burst ends anyway.
          l_gnt = L_VALID;
          p_gnt = !L_VALID && P_REQ;
        end
        default: begin
          p_gnt = 1'b0;
          l_gnt = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ST_PIPE_OWN: begin
        if (l_gnt) begin
          wait_cnt_d = '0;
        end else if (L_VALID) begin
          // Loader asked and lost to the pipeline.
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = ST_LOAD_OWN;
            wait_cnt_d = '0;
            beat_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ST_LOAD_OWN: begin
        wait_cnt_d = '0;
        if (l_gnt) begin
          if (L_LAST || (beat_cnt_q == BEAT_LAST)) begin
            state_d    = ST_PIPE_OWN;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end else begin
          // Loader went quiet: abandon the burst rather than block the pipeline.
          state_d    = ST_PIPE_OWN;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_PIPE_OWN;
        wait_cnt_d = '0;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Reads remember their issuer for the single cycle of SRAM latency.
  always_comb begin
    p_rvalid_d = p_gnt && !P_WE;
    l_rvalid_d = l_gnt && !L_WE;
  end

  // ---------------------------------------------------------------------------
  // SRAM drive: only the granted requester reaches the port.
  // ---------------------------------------------------------------------------
  always_comb begin
    MEM_csb0  = 1'b1;
    MEM_web0  = 1'b1;
    MEM_addr0 = '0;
    MEM_din0  = '0;
    if (p_gnt) begin
      MEM_csb0  = 1'b0;
      MEM_web0  = ~P_WE;
      MEM_addr0 = P_ADDR;
      MEM_din0  = P_WDATA;
    end else if (l_gnt) begin
      MEM_csb0  = 1'b0;
      MEM_web0  = ~L_WE;
      MEM_addr0 = L_ADDR;
      MEM_din0  = L_WDATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Requester-facing outputs. The registered flags are masked by RST so a
  // read issued just before reset never reports data while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    P_STALL  = P_REQ && !p_gnt && !RST;
    L_READY  = l_gnt;
    P_RVALID = p_rvalid_q && !RST;
    L_RVALID = l_rvalid_q && !RST;
    P_RDATA  = MEM_dout0;
    L_RDATA  = MEM_dout0;
    LOAD_OWN = (state_q == ST_LOAD_OWN) && !RST;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_PIPE_OWN;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
      p_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      p_rvalid_q <= p_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter with a small behavioural SRAM model
// (one-cycle read latency, unwritten words read back as 0xC0DE00<addr>).
module tb_dmem_port_arbiter;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 32;
  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic              P_REQ, P_WE;
  logic [ADDR_W-1:0] P_ADDR;
  logic [DATA_W-1:0] P_WDATA;
  logic              P_STALL, P_RVALID;
  logic [DATA_W-1:0] P_RDATA;
  logic              L_VALID, L_WE, L_LAST;
  logic [ADDR_W-1:0] L_ADDR;
  logic [DATA_W-1:0] L_WDATA;
  logic              L_READY, L_RVALID;
  logic [DATA_W-1:0] L_RDATA;
  logic              MEM_csb0, MEM_web0;
  logic [ADDR_W-1:0] MEM_addr0;
  logic [DATA_W-1:0] MEM_din0;
  logic [DATA_W-1:0] MEM_dout0;
  logic              LOAD_OWN;

  int n_vec = 0;
  int n_err = 0;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .CLK(CLK), .RST(RST),
    .P_REQ(P_REQ), .P_WE(P_WE), .P_ADDR(P_ADDR), .P_WDATA(P_WDATA),
    .P_STALL(P_STALL), .P_RVALID(P_RVALID), .P_RDATA(P_RDATA),
    .L_VALID(L_VALID), .L_WE(L_WE), .L_LAST(L_LAST), .L_ADDR(L_ADDR), .L_WDATA(L_WDATA),
    .L_READY(L_READY), .L_RVALID(L_RVALID), .L_RDATA(L_RDATA),
    .MEM_csb0(MEM_csb0), .MEM_web0(MEM_web0), .MEM_addr0(MEM_addr0),
    .MEM_din0(MEM_din0), .MEM_dout0(MEM_dout0),
    .LOAD_OWN(LOAD_OWN)
  );

  always #5 CLK = ~CLK;

  // Behavioural SRAM
  logic              mem_clr;
  logic [DATA_W-1:0] mem [256];
  logic [255:0]      written;

  always @(posedge CLK) begin
    if (mem_clr) begin
      written   <= '0;
      MEM_dout0 <= '0;
    end else if (!MEM_csb0) begin
      if (!MEM_web0) begin
        mem[MEM_addr0[7:0]]     <= MEM_din0;
        written[MEM_addr0[7:0]] <= 1'b1;
      end else begin
        MEM_dout0 <= written[MEM_addr0[7:0]] ? mem[MEM_addr0[7:0]]
                                             : {24'hC0DE00, MEM_addr0[7:0]};
      end
    end
  end

  task automatic drive_idle();
    P_REQ = 1'b0; P_WE = 1'b0; L_VALID = 1'b0; L_WE = 1'b0; L_LAST = 1'b0;
  endtask

  // Single accepted loader beat with the pipeline idle: leaves wait_cnt at 0.
  task automatic clear_wait();
    P_REQ = 1'b0; L_VALID = 1'b1; L_WE = 1'b1; L_LAST = 1'b0;
    L_ADDR = 20'hF0; L_WDATA = 32'hFFFF_0000;
    @(negedge CLK);
  endtask

  // Starve the loader for MAX_WAIT cycles; returns at the first LOAD_OWN cycle.
  task automatic starve();
    clear_wait();
    P_REQ = 1'b1; P_WE = 1'b0; P_ADDR = 20'h1C;
    L_VALID = 1'b1; L_WE = 1'b1; L_ADDR = 20'h40; L_WDATA = 32'h100;
    repeat (MAX_WAIT) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; P_REQ = 1'b1; P_WE = 1'b0; P_ADDR = 20'h55; L_VALID = 1'b1; L_WE = 1'b1;
    L_ADDR = 20'h66; L_WDATA = 32'h1234;
    #1;
    n_vec++; if (MEM_csb0 !== 1'b1) begin n_err++; $display("FAIL rst_csb got %b want 1", MEM_csb0); end
    n_vec++; if (MEM_web0 !== 1'b1) begin n_err++; $display("FAIL rst_web got %b want 1", MEM_web0); end
    n_vec++; if (MEM_addr0 !== 20'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", MEM_addr0); end
    n_vec++; if (MEM_din0 !== 32'h0) begin n_err++; $display("FAIL rst_din got %h want 0", MEM_din0); end
    n_vec++; if (L_READY !== 1'b0) begin n_err++; $display("FAIL rst_lready got %b want 0", L_READY); end
    n_vec++; if (P_STALL !== 1'b0) begin n_err++; $display("FAIL rst_pstall got %b want 0", P_STALL); end
    n_vec++; if (LOAD_OWN !== 1'b0) begin n_err++; $display("FAIL rst_loadown got %b want 0", LOAD_OWN); end
    @(negedge CLK);
    RST = 1'b0; drive_idle();
    #1;
    n_vec++; if (LOAD_OWN !== 1'b0) begin n_err++; $display("FAIL post_rst_loadown got %b want 0", LOAD_OWN); end
    n_vec++; if (P_RVALID !== 1'b0) begin n_err++; $display("FAIL post_rst_prvalid got %b want 0", P_RVALID); end
    n_vec++; if (L_RVALID !== 1'b0) begin n_err++; $display("FAIL post_rst_lrvalid got %b want 0", L_RVALID); end
    n_vec++; if (MEM_csb0 !== 1'b1) begin n_err++; $display("FAIL post_rst_csb got %b want 1", MEM_csb0); end
    @(negedge CLK);
  endtask

  task automatic test_pipe_rw();
    P_REQ = 1'b1; P_WE = 1'b0; P_ADDR = 20'h1C; P_WDATA = 32'h0;
    #1;
    n_vec++; if (MEM_csb0 !== 1'b0) begin n_err++; $display("FAIL prd_csb got %b want 0", MEM_csb0); end
    n_vec++; if (MEM_web0 !== 1'b1) begin n_err++; $display("FAIL prd_web got %b want 1", MEM_web0); end
    n_vec++; if (MEM_addr0 !== 20'h1C) begin n_err++; $display("FAIL prd_addr got %h want 1c", MEM_addr0); end
    n_vec++; if (P_STALL !== 1'b0) begin n_err++; $display("FAIL prd_stall got %b want 0", P_STALL); end
    @(negedge CLK);
    P_REQ = 1'b0;
    #1;
    n_vec++; if (P_RVALID !== 1'b1) begin n_err++; $display("FAIL prd_rvalid got %b want 1", P_RVALID); end
    n_vec++; if (P_RDATA !== 32'hC0DE001C) begin n_err++; $display("FAIL prd_rdata got %h want c0de001c", P_RDATA); end
    @(negedge CLK);
    P_REQ = 1'b1; P_WE = 1'b1; P_WDATA = 32'h2;
    #1;
    n_vec++; if (MEM_web0 !== 1'b0) begin n_err++; $display("FAIL pwr_web got %b want 0", MEM_web0); end
    n_vec++; if (MEM_din0 !== 32'h2) begin n_err++; $display("FAIL pwr_din got %h want 2", MEM_din0); end
    n_vec++; if (P_RVALID !== 1'b0) begin n_err++; $display("FAIL pwr_rvalid got %b want 0", P_RVALID); end
    @(negedge CLK);
    // Back-to-back reads of the word just written.
    P_WE = 1'b0;
    #1;
    n_vec++; if (P_RVALID !== 1'b0) begin n_err++; $display("FAIL pwr_norvalid got %b want 0", P_RVALID); end
    @(negedge CLK);
    #1;
    n_vec++; if (P_RVALID !== 1'b1) begin n_err++; $display("FAIL b2b_rv1 got %b want 1", P_RVALID); end
    n_vec++; if (P_RDATA !== 32'h2) begin n_err++; $display("FAIL b2b_d1 got %h want 2", P_RDATA); end
    @(negedge CLK);
    P_REQ = 1'b0;
    #1;
    n_vec++; if (P_RVALID !== 1'b1) begin n_err++; $display("FAIL b2b_rv2 got %b want 1", P_RVALID); end
    n_vec++; if (P_RDATA !== 32'h2) begin n_err++; $display("FAIL b2b_d2 got %h want 2", P_RDATA); end
    @(negedge CLK);
    #1;
    n_vec++; if (P_RVALID !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", P_RVALID); end
    @(negedge CLK);
  endtask

  task automatic test_loader();
    P_REQ = 1'b0; L_VALID = 1'b1; L_WE = 1'b1; L_LAST = 1'b1; L_ADDR = 20'h10; L_WDATA = 32'hA5;
    #1;
    n_vec++; if (L_READY !== 1'b1) begin n_err++; $display("FAIL lwr_ready got %b want 1", L_READY); end
    n_vec++; if (MEM_csb0 !== 1'b0) begin n_err++; $display("FAIL lwr_csb got %b want 0", MEM_csb0); end
    n_vec++; if (MEM_web0 !== 1'b0) begin n_err++; $display("FAIL lwr_web got %b want 0", MEM_web0); end
    n_vec++; if (MEM_addr0 !== 20'h10) begin n_err++; $display("FAIL lwr_addr got %h want 10", MEM_addr0); end
    n_vec++; if (MEM_din0 !== 32'hA5) begin n_err++; $display("FAIL lwr_din got %h want a5", MEM_din0); end
    @(negedge CLK);
    L_WE = 1'b0;
    #1;
    n_vec++; if (L_READY !== 1'b1) begin n_err++; $display("FAIL lrd_ready got %b want 1", L_READY); end
    n_vec++; if (L_RVALID !== 1'b0) begin n_err++; $display("FAIL lwr_norvalid got %b want 0", L_RVALID); end
    @(negedge CLK);
    drive_idle();
    #1;
    n_vec++; if (L_RVALID !== 1'b1) begin n_err++; $display("FAIL lrd_rvalid got %b want 1", L_RVALID); end
    n_vec++; if (L_RDATA !== 32'hA5) begin n_err++; $display("FAIL lrd_rdata got %h want a5", L_RDATA); end
    n_vec++; if (P_RVALID !== 1'b0) begin n_err++; $display("FAIL lrd_prvalid got %b want 0", P_RVALID); end
    @(negedge CLK);
  endtask

  task automatic test_starvation();
    int grants;
    logic [ADDR_W-1:0] exp_a;
    grants = 0;
    clear_wait();
    P_REQ = 1'b1; P_WE = 1'b0; P_ADDR = 20'h1C;
    L_VALID = 1'b1; L_WE = 1'b1; L_LAST = 1'b0; L_ADDR = 20'h40; L_WDATA = 32'h100;
    for (int i = 0; i < MAX_WAIT; i++) begin
      #1;
      n_vec++; if (L_READY !== 1'b0 || P_STALL !== 1'b0 || LOAD_OWN !== 1'b0) begin
        n_err++; $display("FAIL starve_deny[%0d] got ready=%b stall=%b own=%b want 0/0/0", i, L_READY, P_STALL, LOAD_OWN);
      end
      @(negedge CLK);
    end
    for (int i = 0; i < BURST_MAX; i++) begin
      L_ADDR = 20'h40 + 20'(i); L_WDATA = 32'h100 + 32'(i);
      exp_a = 20'h40 + 20'(i);
      #1;
      if (L_READY === 1'b1) grants++;
      n_vec++; if (LOAD_OWN !== 1'b1 || P_STALL !== 1'b1 || MEM_addr0 !== exp_a) begin
        n_err++; $display("FAIL burst[%0d] got own=%b stall=%b addr=%h want 1/1/%h", i, LOAD_OWN, P_STALL, MEM_addr0, exp_a);
      end
      @(negedge CLK);
    end
    n_vec++; if (grants !== BURST_MAX) begin n_err++; $display("FAIL burst_grants got %0d want %0d", grants, BURST_MAX); end
    L_ADDR = 20'h50;
    #1;
    n_vec++; if (LOAD_OWN !== 1'b0 || P_STALL !== 1'b0 || L_READY !== 1'b0) begin
      n_err++; $display("FAIL burst_end got own=%b stall=%b ready=%b want 0/0/0", LOAD_OWN, P_STALL, L_READY);
    end
    @(negedge CLK);
    drive_idle();
    @(negedge CLK);
  endtask

  task automatic test_last_beat();
    starve();
    for (int b = 1; b <= 3; b++) begin
      L_LAST = (b == 3); L_ADDR = 20'h80 + 20'(b);
      #1;
      n_vec++; if (L_READY !== 1'b1 || P_STALL !== 1'b1) begin
        n_err++; $display("FAIL last_beat[%0d] got ready=%b stall=%b want 1/1", b, L_READY, P_STALL);
      end
      @(negedge CLK);
    end
    // Loader still asks: must lose now that the burst has ended.
    L_LAST = 1'b0;
    #1;
    n_vec++; if (LOAD_OWN !== 1'b0 || L_READY !== 1'b0 || P_STALL !== 1'b0) begin
      n_err++; $display("FAIL last_return got own=%b ready=%b stall=%b want 0/0/0", LOAD_OWN, L_READY, P_STALL);
    end
    n_vec++; if (MEM_csb0 !== 1'b0 || MEM_web0 !== 1'b1 || MEM_addr0 !== 20'h1C) begin
      n_err++; $display("FAIL last_pread got csb=%b web=%b addr=%h want 0/1/1c", MEM_csb0, MEM_web0, MEM_addr0);
    end
    @(negedge CLK);
    drive_idle();
    #1;
    n_vec++; if (P_RVALID !== 1'b1 || P_RDATA !== 32'h2) begin
      n_err++; $display("FAIL last_prvalid got rv=%b data=%h want 1/2", P_RVALID, P_RDATA);
    end
    @(negedge CLK);
  endtask

  task automatic test_abandon();
    starve();
    #1;
    n_vec++; if (L_READY !== 1'b1) begin n_err++; $display("FAIL abn_beat got %b want 1", L_READY); end
    @(negedge CLK);
    L_VALID = 1'b0;
    #1;
    n_vec++; if (LOAD_OWN !== 1'b1 || P_STALL !== 1'b0 || L_READY !== 1'b0) begin
      n_err++; $display("FAIL abn_pgrant got own=%b stall=%b ready=%b want 1/0/0", LOAD_OWN, P_STALL, L_READY);
    end
    n_vec++; if (MEM_csb0 !== 1'b0 || MEM_addr0 !== 20'h1C) begin
      n_err++; $display("FAIL abn_mem got csb=%b addr=%h want 0/1c", MEM_csb0, MEM_addr0);
    end
    @(negedge CLK);
    drive_idle();
    #1;
    n_vec++; if (LOAD_OWN !== 1'b0 || P_RVALID !== 1'b1) begin
      n_err++; $display("FAIL abn_next got own=%b prv=%b want 0/1", LOAD_OWN, P_RVALID);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    starve();
    L_WE = 1'b0; L_ADDR = 20'h10;
    #1;
    n_vec++; if (L_READY !== 1'b1 || LOAD_OWN !== 1'b1) begin
      n_err++; $display("FAIL rmid_read got ready=%b own=%b want 1/1", L_READY, LOAD_OWN);
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_vec++; if (L_RVALID !== 1'b0 || MEM_csb0 !== 1'b1 || LOAD_OWN !== 1'b0) begin
      n_err++; $display("FAIL rmid_hold got lrv=%b csb=%b own=%b want 0/1/0", L_RVALID, MEM_csb0, LOAD_OWN);
    end
    n_vec++; if (L_READY !== 1'b0 || P_STALL !== 1'b0) begin
      n_err++; $display("FAIL rmid_gnt got ready=%b stall=%b want 0/0", L_READY, P_STALL);
    end
    @(negedge CLK);
    RST = 1'b0; L_VALID = 1'b0; P_REQ = 1'b1; P_WE = 1'b0; P_ADDR = 20'h1C;
    #1;
    n_vec++; if (P_STALL !== 1'b0 || MEM_csb0 !== 1'b0 || LOAD_OWN !== 1'b0 || L_RVALID !== 1'b0) begin
      n_err++; $display("FAIL rmid_release got stall=%b csb=%b own=%b lrv=%b want 0/0/0/0", P_STALL, MEM_csb0, LOAD_OWN, L_RVALID);
    end
    @(negedge CLK);
    drive_idle();
    #1;
    n_vec++; if (P_RVALID !== 1'b1 || P_RDATA !== 32'h2) begin
      n_err++; $display("FAIL rmid_prvalid got rv=%b data=%h want 1/2", P_RVALID, P_RDATA);
    end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; mem_clr = 1'b1;
    drive_idle();
    P_ADDR = '0; P_WDATA = '0; L_ADDR = '0; L_WDATA = '0;
    @(negedge CLK);
    mem_clr = 1'b0;
    test_reset();
    test_pipe_rw();
    test_loader();
    test_starvation();
    test_last_beat();
    test_abandon();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Owns the single port of the data SRAM (sram_32_1024_freepdk45) and shares it between two requesters:
  - the pipeline MEM stage;
  - a loader requester (testbench preload / memory dump engine).
- Default priority goes to the pipeline. A starvation counter grants the loader a bounded burst, and stalls the pipeline while the burst runs.
- Tracks the one-cycle SRAM read latency and routes read data back to whichever requester issued the read.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 32, data width.
- MAX_WAIT, 8, consecutive denied loader cycles before a loader burst is forced (MAX_WAIT >= 1).
- BURST_MAX, 16, maximum loader beats per forced burst (BURST_MAX >= 1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- P_REQ  in  1  pipeline access request.
- P_WE  in  1  pipeline write (1) / read (0).
- P_ADDR  in  ADDR_W  pipeline address.
- P_WDATA  in  DATA_W  pipeline write data.
- P_STALL  out  1  pipeline request denied this cycle; pipeline holds its request.
- P_RVALID  out  1  P_RDATA valid (read issued the previous cycle).
- P_RDATA  out  DATA_W  read data.
- L_VALID  in  1  loader beat valid.
- L_WE  in  1  loader write (1) / read (0).
- L_LAST  in  1  last beat of the loader burst.
- L_ADDR  in  ADDR_W  loader address.
- L_WDATA  in  DATA_W  loader write data.
- L_READY  out  1  loader beat accepted this cycle.
- L_RVALID  out  1  L_RDATA valid.
- L_RDATA  out  DATA_W  read data.
- MEM_csb0  out  1  SRAM chip select, active-low.
- MEM_web0  out  1  SRAM write enable, active-low.
- MEM_addr0  out  ADDR_W  SRAM address.
- MEM_din0  out  DATA_W  SRAM write data.
- MEM_dout0  in  DATA_W  SRAM read data, valid one cycle after a read.
- LOAD_OWN  out  1  state indicator: 1 while in LOAD_OWN.

Behaviour:
- Reset state and values (while RST=1, and on the cycle after reset deasserts):
  - state=PIPE_OWN; wait_cnt=0; beat_cnt=0; P_RVALID=0; L_RVALID=0; LOAD_OWN=0.
  - While RST=1 all grant outputs are forced inactive: MEM_csb0=1, MEM_web0=1, MEM_addr0=0, MEM_din0=0, L_READY=0, P_STALL=0.
- Grant logic is combinational within the cycle; state and counters are registered. At most one requester is granted per cycle.
- PIPE_OWN state:
  - P_REQ=1: pipeline granted, P_STALL=0, L_READY=0. If L_VALID=1, wait_cnt increments.
  - P_REQ=0 and L_VALID=1: loader granted (L_READY=1), wait_cnt cleared to 0.
  - Neither requesting: SRAM idle.
  - Transition: a denied loader cycle with wait_cnt==MAX_WAIT-1 moves the state to LOAD_OWN next cycle, with wait_cnt=0 and beat_cnt=0.
- LOAD_OWN state:
  - L_VALID=1: loader granted, L_READY=1, P_STALL=P_REQ, beat_cnt increments.
  - Return to PIPE_OWN after an accepted beat with L_LAST=1, or after an accepted beat with beat_cnt==BURST_MAX-1.
  - L_VALID=0: loader not granted; the pipeline is granted if P_REQ=1 (P_STALL=0), and the state returns to PIPE_OWN next cycle (burst abandoned).
- SRAM drive:
  - Granted requester: MEM_csb0=0, MEM_web0=~WE, MEM_addr0/MEM_din0 taken from that requester.
  - No grant: MEM_csb0=1, MEM_web0=1, MEM_addr0=0, MEM_din0=0.
- Read return:
  - A granted read sets the owner's RVALID register for exactly the following cycle.
  - P_RDATA and L_RDATA both pass MEM_dout0 through combinationally.
  - Writes never set RVALID.
  - Back-to-back reads produce consecutive RVALID pulses.
- Stall rule: P_STALL=1 only when P_REQ=1 and the pipeline is denied. The pipeline holds its P_* signals until P_STALL=0.
- Counter widths: wait_cnt is $clog2(MAX_WAIT+1) bits; beat_cnt is $clog2(BURST_MAX+1) bits. Neither counter ever exceeds its terminal value.
- Reset mid-burst: returns to PIPE_OWN and drops any pending RVALID. The loader re-issues the beat.

Test Plan:
- Pipeline read at 0x001C, then write 0x2 at 0x001C, L_VALID=0:
  - cycle 0: MEM_csb0=0, MEM_web0=1, no stall;
  - cycle 1: P_RVALID=1;
  - cycle 2: MEM_web0=0, MEM_din0=0x2, P_RVALID=0.
- P_REQ=0, loader single write beat to 0x10, data 0xA5:
  - L_READY=1 same cycle; MEM_csb0=0, MEM_web0=0, MEM_addr0=0x10; wait_cnt=0.
- Starvation, MAX_WAIT=8, BURST_MAX=16; P_REQ=1 continuously, L_VALID=1:
  - 8 denied cycles, then LOAD_OWN=1;
  - loader receives 16 consecutive L_READY while P_STALL=1;
  - then returns to PIPE_OWN and P_STALL=0.
- Forced burst with L_LAST=1 on beat 3:
  - exactly 3 loader grants, then PIPE_OWN;
  - a pipeline read in the next cycle gets P_RVALID=1 one cycle later.
- In LOAD_OWN, L_VALID drops to 0 while P_REQ=1:
  - pipeline granted that cycle (P_STALL=0); LOAD_OWN=0 next cycle.
- RST=1 asserted on the cycle after a loader read in LOAD_OWN:
  - L_RVALID=0, MEM_csb0=1, LOAD_OWN=0 while RST=1;
  - after release, a pipeline request is granted immediately.
